// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the system reset; retries on timeout and latches FAULT after MAX_RETRIES.
module pll_lock_sequencer #(
  parameter int PLL_RESET_CYCLES    = 20,
  parameter int LOCK_STABLE_CYCLES  = 2000,  // must be >= 2
  parameter int LOCK_TIMEOUT_CYCLES = 40000, // must exceed LOCK_STABLE_CYCLES
  parameter int MAX_RETRIES         = 3      // 1..7
) (
  input  logic       referenceclk,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [2:0] retry_count
);

  localparam int HW = (PLL_RESET_CYCLES > 1)    ? $clog2(PLL_RESET_CYCLES)    : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;

  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_t;

  state_t         state, nxt;
  logic           lock_m, lock_s;
  logic [HW-1:0]  hold_cnt;
  logic [TW-1:0]  att_tmr;
  logic [SW-1:0]  stb_cnt;
  logic [2:0]     retry_nxt, retry_d;
  logic           pll_resetb_d, sys_resetn_d, ready_d, fault_d, lock_lost_d;
  logic           hold_done, timeout, stable_done, fail_dest_fault;

  assign retry_nxt       = retry_count + 3'd1;
  assign hold_done       = (hold_cnt == HW'(PLL_RESET_CYCLES - 1));
  assign timeout         = (att_tmr == TW'(LOCK_TIMEOUT_CYCLES - 1));
  // The WAIT_LOCK cycle that first sees lock_s counts toward the stable run.
  assign stable_done     = lock_s && (stb_cnt == SW'(LOCK_STABLE_CYCLES - 2));
  assign fail_dest_fault = (retry_nxt == 3'(MAX_RETRIES));

  always_ff @(posedge referenceclk or negedge reset) begin
    if (!reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  // State and registered outputs
  always_ff @(posedge referenceclk or negedge reset) begin
    if (!reset) begin
      state       <= S_HOLD;
      pll_resetb  <= 1'b0;
      sys_resetn  <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 3'd0;
    end else begin
      state       <= nxt;
      pll_resetb  <= pll_resetb_d;
      sys_resetn  <= sys_resetn_d;
      ready       <= ready_d;
      fault       <= fault_d;
      lock_lost   <= lock_lost_d;
      retry_count <= retry_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_HOLD:   if (hold_done) nxt = S_WAIT;
      S_WAIT: begin
        if (lock_s)       nxt = S_STABLE;
        else if (timeout) nxt = fail_dest_fault ? S_FAULT : S_HOLD;
      end
      S_STABLE: begin
        if (stable_done)  nxt = S_RUN;
        else if (timeout) nxt = fail_dest_fault ? S_FAULT : S_HOLD;
        else if (!lock_s) nxt = S_WAIT;
      end
      S_RUN:    if (!lock_s) nxt = S_HOLD;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_HOLD;
    endcase
  end

  always_comb begin
    pll_resetb_d = (nxt != S_HOLD) && (nxt != S_FAULT);
    sys_resetn_d = (nxt == S_RUN);
    ready_d      = (nxt == S_RUN);
    fault_d      = (nxt == S_FAULT);
    lock_lost_d  = lock_lost | ((state == S_RUN) && (nxt == S_HOLD));
    retry_d      = retry_count;
    if ((state == S_WAIT || state == S_STABLE) && (nxt == S_HOLD || nxt == S_FAULT))
      retry_d = retry_nxt;
    else if (state == S_RUN && nxt == S_HOLD)
      retry_d = 3'd0;
  end

  // Attempt timer saturates at its terminal value so it never wraps.
  always_ff @(posedge referenceclk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      att_tmr  <= '0;
      stb_cnt  <= '0;
    end else begin
      hold_cnt <= (state == S_HOLD && !hold_done) ? hold_cnt + 1'b1 : '0;
      if (state == S_HOLD)
        att_tmr <= '0;
      else if ((state == S_WAIT || state == S_STABLE) && !timeout)
        att_tmr <= att_tmr + 1'b1;
      stb_cnt  <= (state == S_STABLE && lock_s) ? stb_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with P=4, L=8, T=32, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic       pll_resetb, sys_resetn, ready, fault, lock_lost;
  logic [2:0] retry_count;
  int         n_chk = 0;
  int         n_fail = 0;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .referenceclk(clk), .reset(rst_n), .lock(lock),
    .pll_resetb(pll_resetb), .sys_resetn(sys_resetn), .ready(ready),
    .fault(fault), .lock_lost(lock_lost), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  // Packed view: {pll_resetb, sys_resetn, ready, fault, lock_lost, retry_count[2:0]}
  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pll_resetb, sys_resetn, ready, fault, lock_lost, retry_count};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release reset 1 unit after an edge: that point is cycle 0.
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, no clock edge needed
    #2;
    chk("reset_vals", 8'h00);
    step(2);
    chk("reset_held", 8'h00);

    // Normal bring-up, lock from cycle 10
    release_rst();
    step(3);  chk("bring_c3_hold", 8'h00);
    step(1);  chk("bring_c4_pllrel", 8'h80);
    step(6);  lock = 1'b1;                   // cycle 10
    step(9);  chk("bring_c19_notyet", 8'h80);
    step(1);  chk("bring_c20_run", 8'hE0);

    // Lock loss in RUN: drop at cycle 20
    lock = 1'b0;
    step(2);  chk("loss_c22_still_run", 8'hE0);
    step(1);  chk("loss_c23_hold", 8'h08);
    step(3);  chk("loss_c26_hold", 8'h08);
    step(1);  chk("loss_c27_pllrel", 8'h88);
    lock = 1'b1;                              // cycle 27
    step(9);  chk("loss_c36_notyet", 8'h88);
    step(1);  chk("loss_c37_rerun", 8'hE8);

    // Reset while in RUN
    rst_n = 1'b0;
    #1;       chk("rst_in_run", 8'h00);
    lock = 1'b0;

    // Lock glitch during STABLE
    release_rst();
    step(4);  chk("glitch_c4_pllrel", 8'h80);
    lock = 1'b1;                              // cycle 4
    step(5);  lock = 1'b0;                    // cycle 9
    step(1);  lock = 1'b1;                    // cycle 10
    step(4);  chk("glitch_c14_no_early_run", 8'h80);
    step(5);  chk("glitch_c19_notyet", 8'h80);
    step(1);  chk("glitch_c20_run", 8'hE0);

    rst_n = 1'b0;
    #1;       chk("rst_after_glitch", 8'h00);
    lock = 1'b0;

    // Coincidence: lock_s rises on the timeout cycle (cycle 35)
    release_rst();
    step(33); lock = 1'b1;                    // cycle 33
    step(2);  chk("coin_c35_wait", 8'h80);
    step(1);  chk("coin_c36_stable_no_retry", 8'h80);

    // Reset while in STABLE
    rst_n = 1'b0;
    #1;       chk("rst_in_stable", 8'h00);
    lock = 1'b0;

    // Timeout, retry, then FAULT
    release_rst();
    step(35); chk("to_c35_wait", 8'h80);
    step(1);  chk("to_c36_retry1", 8'h01);
    step(3);  chk("to_c39_hold", 8'h01);
    step(1);  chk("to_c40_pllrel", 8'h81);
    step(31); chk("to_c71_wait", 8'h81);
    step(1);  chk("to_c72_fault", 8'h12);
    lock = 1'b1;
    step(20); chk("fault_terminal", 8'h12);

    // Reset in FAULT, restart at HOLD cycle 0
    rst_n = 1'b0;
    #1;       chk("rst_in_fault", 8'h00);
    lock = 1'b0;
    release_rst();
    step(3);  chk("restart_c3_hold", 8'h00);
    step(1);  chk("restart_c4_pllrel", 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
